// File: rtl/wall_probe.sv
// Scans a BOX_W x BOX_H window of the mono maze ROM and reports whether any pixel is a wall.
// Stops at the first wall; pixels past the image edge count as walls.
module wall_probe #(
    parameter int BOX_W    = 7,
    parameter int BOX_H    = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  req_x,
    input  logic [6:0]  req_y,
    output logic [14:0] rom_address,
    input  logic        rom_q,
    output logic        busy,
    output logic        done,
    output logic        blocked
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam int         N       = BOX_W * BOX_H;
    localparam logic [3:0] OX_LAST = 4'(BOX_W - 1);
    localparam logic [7:0] K_LAST  = 8'(N - 1);

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [3:0]  ox_q, ox_d, oy_q, oy_d;
    logic [7:0]  k_q, k_d;
    logic        blocked_q, blocked_d;
    // Sample pipeline: tracks the address issued last cycle while the ROM answers.
    logic        vld_q, vld_d;
    logic        oob_q, oob_d;
    logic [7:0]  idx_q, idx_d;

    logic [8:0]  px;
    logic [7:0]  py;
    logic        oob;
    logic        wall;
    logic [14:0] lin_addr;

    assign px       = {1'b0, x_q} + {5'b0, ox_q};
    assign py       = {1'b0, y_q} + {4'b0, oy_q};
    assign oob      = (px >= 9'(SCREEN_W)) || (py >= 8'(SCREEN_H));
    assign lin_addr = 15'(px) + 15'(SCREEN_W) * 15'(py);
    assign wall     = vld_q && (rom_q || oob_q);

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign blocked = blocked_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        k_d         = k_q;
        blocked_d   = blocked_q;
        vld_d       = (state_q == SCAN) && !wall;
        oob_d       = oob;
        idx_d       = k_q;
        rom_address = (state_q == SCAN && !oob) ? lin_addr : 15'd0;

        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (start) begin
                    state_d   = SCAN;
                    x_d       = req_x;
                    y_d       = req_y;
                    ox_d      = 4'd0;
                    oy_d      = 4'd0;
                    k_d       = 8'd0;
                    blocked_d = 1'b0;
                end
            end
            SCAN: begin
                if (wall) begin
                    blocked_d = 1'b1;
                    state_d   = DONE;
                end else if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 8'd1;
                    if (ox_q == OX_LAST) begin
                        ox_d = 4'd0;
                        oy_d = oy_q + 4'd1;
                    end else begin
                        ox_d = ox_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (wall) begin
                    blocked_d = 1'b1;
                    state_d   = DONE;
                end else if (vld_q && idx_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            k_q       <= '0;
            blocked_q <= 1'b0;
            vld_q     <= 1'b0;
            oob_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            k_q       <= k_d;
            blocked_q <= blocked_d;
            vld_q     <= vld_d;
            oob_q     <= oob_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_wall_probe.sv
// Directed bench for wall_probe: table of scan cases plus hand-written busy/reset sequences.
module tb_wall_probe;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [14:0] rom_address;
    logic        rom_q;
    logic        busy, done, blocked;

    always #5 clk = ~clk;

    bit rom_bits [0:32767];
    always @(posedge clk) rom_q <= rom_bits[rom_address];

    wall_probe dut (
        .clk(clk), .reset(reset), .start(start), .req_x(req_x), .req_y(req_y),
        .rom_address(rom_address), .rom_q(rom_q), .busy(busy), .done(done), .blocked(blocked)
    );

    typedef struct {
        int x; int y; int wall; int de; int blk; int ck; int ca;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [14:0] addr_log [0:63];
    logic        busy_log [0:63];
    logic        done_log [0:63];
    logic        blk_log  [0:63];
    int          run_done_e, run_ndone;
    logic        run_blk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic set_wall(input int a);
        for (int i = 0; i < 32768; i++) rom_bits[i] = 1'b0;
        if (a >= 0) rom_bits[a] = 1'b1;
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    // Log index e holds outputs during the cycle after edge e.
    task automatic run_scan(input int x, input int y, input int ign_e, input int rst_e, input int lim);
        req_x = 8'(x);
        req_y = 7'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_done_e = -1;
        run_ndone  = 0;
        run_blk    = 1'b0;
        for (int e = 0; e < lim; e++) begin
            addr_log[e] = rom_address;
            busy_log[e] = busy;
            done_log[e] = done;
            blk_log[e]  = blocked;
            if (done) begin
                run_ndone++;
                if (run_done_e < 0) begin
                    run_done_e = e;
                    run_blk    = blocked;
                end
            end
            start = (e + 1 == ign_e);
            if (e + 1 == ign_e) begin
                req_x = 8'd50;
                req_y = 7'd50;
            end
            reset = (e + 1 == rst_e);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    function automatic int exp_addr(input int x, input int y, input int e, input int de);
        int px, py;
        if (e >= 49 || e >= de) return 0;
        px = x + e % 7;
        py = y + e / 7;
        if (px >= 160 || py >= 120) return 0;
        return px + 160 * py;
    endfunction

    // One comparison per sequence: first mismatching cycle, else the last scanned cycle.
    task automatic chk_seq(input string name, input int x, input int y, input int de, input int lim);
        int idx;
        idx = (de < lim) ? de : lim - 1;
        for (int e = lim - 1; e >= 0; e--)
            if (int'(addr_log[e]) != exp_addr(x, y, e, de)) idx = e;
        chk($sformatf("%s_addr@%0d", name, idx), int'(addr_log[idx]), exp_addr(x, y, idx, de));
    endtask

    initial begin
        vec_t tbl [8];
        int   de;
        tbl[0] = '{10,  20,  -1,   50, 0, 48, 4176};
        tbl[1] = '{10,  20,  3533, 19, 1, 18, 3534};
        tbl[2] = '{155, 0,   -1,   7,  1, 5,  0};
        tbl[3] = '{0,   115, -1,   37, 1, 35, 0};
        tbl[4] = '{10,  20,  3210, 2,  1, 1,  3211};
        tbl[5] = '{10,  20,  4176, 50, 1, 49, 0};
        tbl[6] = '{10,  20,  4175, 49, 1, 48, 4176};
        tbl[7] = '{153, 113, -1,   50, 0, 48, 19199};

        reset = 1'b1; start = 1'b0; req_x = '0; req_y = '0;
        set_wall(-1);
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_blocked", int'(blocked), 0);
        chk("reset_addr", int'(rom_address), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            set_wall(tbl[i].wall);
            run_scan(tbl[i].x, tbl[i].y, -1, -1, 60);
            de = tbl[i].de;
            chk($sformatf("v%0d_done_edge", i), run_done_e, de);
            chk($sformatf("v%0d_blocked", i), int'(run_blk), tbl[i].blk);
            chk($sformatf("v%0d_ndone", i), run_ndone, 1);
            chk($sformatf("v%0d_addr_k%0d", i, tbl[i].ck), int'(addr_log[tbl[i].ck]), tbl[i].ca);
            chk($sformatf("v%0d_busy_start", i), int'(busy_log[0]), 1);
            chk($sformatf("v%0d_blk_cleared", i), int'(blk_log[0]), 0);
            chk($sformatf("v%0d_busy_at_done", i), int'(busy_log[de]), 1);
            chk($sformatf("v%0d_busy_fall", i), int'(busy_log[de + 1]), 0);
            chk($sformatf("v%0d_blk_held", i), int'(blk_log[de + 2]), tbl[i].blk);
            chk_seq($sformatf("v%0d", i), tbl[i].x, tbl[i].y, de, 60);
        end

        // start while busy is dropped
        set_wall(-1);
        run_scan(10, 20, 10, -1, 60);
        chk("ign_done_edge", run_done_e, 50);
        chk("ign_ndone", run_ndone, 1);
        chk("ign_blocked", int'(run_blk), 0);
        chk_seq("ign", 10, 20, 50, 60);

        // reset mid-scan, then a fresh scan with start at absolute edge 22
        run_scan(10, 20, -1, 20, 21);
        chk("rst_busy_before", int'(busy_log[19]), 1);
        chk("rst_busy", int'(busy_log[20]), 0);
        chk("rst_done", int'(done_log[20]), 0);
        chk("rst_blocked", int'(blk_log[20]), 0);
        chk("rst_addr", int'(addr_log[20]), 0);
        chk("rst_ndone", run_ndone, 0);
        run_scan(10, 20, -1, -1, 60);
        chk("rst_rerun_done_edge", run_done_e, 50);
        chk("rst_rerun_blocked", int'(run_blk), 0);
        chk_seq("rst_rerun", 10, 20, 50, 60);

        // reset landing on the done cycle loses the result
        set_wall(3210);
        run_scan(10, 20, -1, 2, 10);
        chk("rstdone_done", int'(done_log[2]), 0);
        chk("rstdone_blocked", int'(blk_log[2]), 0);
        chk("rstdone_ndone", run_ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
